crossbar_arbiter: RTL

Packet-level round-robin arbiter for the 3x3 switch crossbar. It reads the head word of each of the three input FIFOs (show-ahead), decodes the destination port, and grants each output port to one input at a time for a whole packet. It drives the FIFO read requests and the per-output source selects consumed by the crossbar mux. Packets to port 00 are drained and discarded, and stalled transfers are aborted after a timeout.

---
 rtl/crossbar_arbiter_if.sv | 42 ++++
 rtl/crossbar_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter_if.sv
// ---------------------------------------------------------------------------
// crossbar_arbiter_if
// Bundles the FIFO-side and crossbar-side signals of the 3x3 packet arbiter.
//
// Signals:
//   data1..3   head word of input FIFO 1..3 (show-ahead)     FIFOs -> arbiter
//   empty1..3  input FIFO empty                              FIFOs -> arbiter
//   rdreq1..3  FIFO pop, head consumed on the same edge      arbiter -> FIFOs
//   sel1..3    source input of output 1..3 (00 = idle)       arbiter -> mux
//   valid1..3  output k carries a word this cycle            arbiter -> mux
//   err1..3    one-cycle pulse, input i aborted by timeout   arbiter -> system
//
// Modports: master = FIFO/crossbar environment, slave = the arbiter.
// ---------------------------------------------------------------------------
interface crossbar_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data1, data2, data3;
  logic              empty1, empty2, empty3;
  logic              rdreq1, rdreq2, rdreq3;
  logic [1:0]        sel1, sel2, sel3;
  logic              valid1, valid2, valid3;
  logic              err1, err2, err3;

  modport master (
    output data1, data2, data3,
    output empty1, empty2, empty3,
    input  rdreq1, rdreq2, rdreq3,
    input  sel1, sel2, sel3,
    input  valid1, valid2, valid3,
    input  err1, err2, err3
  );

  modport slave (
    input  data1, data2, data3,
    input  empty1, empty2, empty3,
    output rdreq1, rdreq2, rdreq3,
    output sel1, sel2, sel3,
    output valid1, valid2, valid3,
    output err1, err2, err3
  );
endinterface

// File: rtl/crossbar_arbiter.sv
// ---------------------------------------------------------------------------
// crossbar_arbiter
// Packet-level round-robin arbiter for a 3x3 crossbar. Each input FIFO head
// is decoded (bits [1:0] destination, bits [7:2] payload length); each free
// output is granted to one waiting input for a whole packet. Packets to
// destination 00 are drained and discarded. A transfer that sees TIMEOUT
// consecutive empty cycles is aborted and flagged on err.
//
// Parameters:
//   DATA_W   FIFO word width (header layout needs at least 8 bits)
//   TIMEOUT  consecutive empty cycles mid-packet before abort, 0 = never
//
// Ports:
//   clk      system clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   bus      crossbar_arbiter_if.slave (FIFO heads/empties in; rdreq, sel,
//            valid and err out)
// ---------------------------------------------------------------------------
module crossbar_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  crossbar_arbiter_if.slave bus
);

  localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort fires on the empty cycle that would bring the count to TIMEOUT.
  localparam logic [STALL_W-1:0] STALL_LAST =
    (TIMEOUT > 0) ? STALL_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DROP = 2'd2
  } in_state_e;

  // Winner is the first requester strictly after 'last' in order 1->2->3->1.
  // Input numbers are 1-based, bit positions 0-based, so input 'last' sits
  // at bit last-1 and the search starts at bit 'last' (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] last);
    logic [2:0] g;
    int         idx;
    g = 3'b000;
    for (int s = 0; s < 3; s++) begin
      idx = (int'(last) + s) % 3;
      if (req[idx] && (g == 3'b000)) g[idx] = 1'b1;
    end
    return g;
  endfunction

  // Flattened views of the interface
  logic [DATA_W-1:0] data_w [3];
  logic [2:0]        empty_w;
  logic [2:0]        rdreq_w;
  logic [2:0]        idle_w;
  logic [2:0]        last_w;
  logic [2:0]        abort_w;
  logic [2:0]        fin_w;
  logic [2:0]        err_w;
  logic [2:0]        gnt_any_w;
  logic [2:0]        gnt_w   [3];
  logic [1:0]        sel_w   [3];
  logic [2:0]        valid_w;
  // Indexed by owner number (1..3); slot 0 is a constant 0 for "no owner".
  logic [3:0]        fin_ext_w;
  logic [3:0]        rd_ext_w;

  assign data_w[0] = bus.data1;
  assign data_w[1] = bus.data2;
  assign data_w[2] = bus.data3;
  assign empty_w   = {bus.empty3, bus.empty2, bus.empty1};

  assign fin_w     = last_w | abort_w;
  assign fin_ext_w = {fin_w, 1'b0};
  assign rd_ext_w  = {rdreq_w, 1'b0};
  assign gnt_any_w = gnt_w[0] | gnt_w[1] | gnt_w[2];

  // -------------------------------------------------------------------------
  // Per-input packet FSM
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_in
    in_state_e          st_q, st_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               hdr_q, hdr_d;    // next read is the header
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
    logic [1:0]         dest_w;
    logic [5:0]         len_w;

    assign dest_w       = data_w[gi][1:0];
    assign len_w        = data_w[gi][7:2];
    assign idle_w[gi]   = (st_q == S_IDLE);
    assign rdreq_w[gi]  = (st_q != S_IDLE) && !empty_w[gi];
    // Header read ends the packet only when N = 0; afterwards the counter
    // holds the words still owed, so the read that sees 1 is the last.
    assign last_w[gi]   = rdreq_w[gi] && (hdr_q ? (cnt_q == 6'd0)
                                                : (cnt_q == 6'd1));
    assign abort_w[gi]  = (TIMEOUT != 0) && (st_q != S_IDLE) &&
                          empty_w[gi] && (stall_q == STALL_LAST);
    assign err_w[gi]    = err_q;

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      stall_d = stall_q;
      err_d   = 1'b0;
      case (st_q)
        S_IDLE: begin
          if (!empty_w[gi]) begin
            if (dest_w == 2'b00) begin
              st_d    = S_DROP;
              cnt_d   = len_w;
              hdr_d   = 1'b1;
              stall_d = '0;
            end else if (gnt_any_w[gi]) begin
              st_d    = S_XFER;
              cnt_d   = len_w;
              hdr_d   = 1'b1;
              stall_d = '0;
            end
          end
        end
        default: begin
          // A read always beats the timeout.
          if (rdreq_w[gi]) begin
            stall_d = '0;
            if (last_w[gi]) begin
              st_d  = S_IDLE;
              hdr_d = 1'b0;
            end else if (hdr_q) begin
              hdr_d = 1'b0;
            end else begin
              cnt_d = cnt_q - 6'd1;
            end
          end else if (abort_w[gi]) begin
            st_d    = S_IDLE;
            hdr_d   = 1'b0;
            stall_d = '0;
            err_d   = 1'b1;
          end else if (TIMEOUT != 0) begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q    <= S_IDLE;
        cnt_q   <= '0;
        hdr_q   <= 1'b0;
        stall_q <= '0;
        err_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        hdr_q   <= hdr_d;
        stall_q <= stall_d;
        err_q   <= err_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-output ownership and round-robin arbitration (output gi+1)
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_out
    logic       busy_q, busy_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] rr_q, rr_d;
    logic [2:0] cand_w;
    logic [2:0] pick_w;

    always_comb begin
      cand_w = 3'b000;
      for (int j = 0; j < 3; j++) begin
        cand_w[j] = idle_w[j] && !empty_w[j] &&
                    (data_w[j][1:0] == 2'(gi + 1));
      end
    end

    // A busy output is not re-arbitrated at its release edge; that gives the
    // single idle cycle between back-to-back packets.
    assign pick_w       = busy_q ? 3'b000 : rr_pick(cand_w, rr_q);
    assign gnt_w[gi]    = pick_w;
    assign sel_w[gi]    = busy_q ? owner_q : 2'b00;
    assign valid_w[gi]  = busy_q && rd_ext_w[owner_q];

    always_comb begin
      busy_d  = busy_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      if (busy_q) begin
        if (fin_ext_w[owner_q]) begin
          busy_d  = 1'b0;
          owner_d = 2'b00;
        end
      end else if (pick_w != 3'b000) begin
        busy_d = 1'b1;
        if (pick_w[0])      owner_d = 2'd1;
        else if (pick_w[1]) owner_d = 2'd2;
        else                owner_d = 2'd3;
        rr_d = owner_d;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        busy_q  <= 1'b0;
        owner_q <= 2'b00;
        rr_q    <= 2'd3;
      end else begin
        busy_q  <= busy_d;
        owner_q <= owner_d;
        rr_q    <= rr_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Interface outputs
  // -------------------------------------------------------------------------
  assign bus.rdreq1 = rdreq_w[0];
  assign bus.rdreq2 = rdreq_w[1];
  assign bus.rdreq3 = rdreq_w[2];
  assign bus.sel1   = sel_w[0];
  assign bus.sel2   = sel_w[1];
  assign bus.sel3   = sel_w[2];
  assign bus.valid1 = valid_w[0];
  assign bus.valid2 = valid_w[1];
  assign bus.valid3 = valid_w[2];
  assign bus.err1   = err_w[0];
  assign bus.err2   = err_w[1];
  assign bus.err3   = err_w[2];

endmodule
